// File: rtl/stage_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// stage_ctrl_pkg
// Shared definitions for the RV32I multi-cycle stage controller:
//   - stage encodings (these are also the values driven on stage_o)
//   - instruction-class codes produced by the decode block
//   - fault codes reported on fault_o
//   - small helpers that classify an instruction class
// No ports; imported by stage_ctrl and stage_wait_timer.
// -----------------------------------------------------------------------------
package stage_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_HALT   = 3'd6
    } stage_e;

    localparam logic [4:0] IT_ILLEGAL = 5'd0;
    localparam logic [4:0] IT_RTYPE   = 5'd1;
    localparam logic [4:0] IT_ITYPE   = 5'd2;
    localparam logic [4:0] IT_STYPE   = 5'd3;
    localparam logic [4:0] IT_BTYPE   = 5'd4;
    localparam logic [4:0] IT_LTYPE   = 5'd5;
    localparam logic [4:0] IT_UTYPE   = 5'd6;
    localparam logic [4:0] IT_JTYPE   = 5'd7;
    localparam logic [4:0] IT_JRTYPE  = 5'd8;

    typedef enum logic [1:0] {
        FAULT_NONE    = 2'd0,
        FAULT_ILLEGAL = 2'd1,
        FAULT_BUS     = 2'd2
    } fault_e;

    // Classes that produce a register-file result.
    function automatic logic itype_writes_rf(input logic [4:0] it);
        return (it == IT_RTYPE) || (it == IT_ITYPE) || (it == IT_LTYPE) ||
               (it == IT_UTYPE) || (it == IT_JTYPE) || (it == IT_JRTYPE);
    endfunction

    // Classes that need a data-memory access.
    function automatic logic itype_is_mem(input logic [4:0] it);
        return (it == IT_LTYPE) || (it == IT_STYPE);
    endfunction

    // Classes that always redirect the PC.
    function automatic logic itype_is_jump(input logic [4:0] it);
        return (it == IT_JTYPE) || (it == IT_JRTYPE);
    endfunction

endpackage

// File: rtl/stage_wait_timer.sv
// -----------------------------------------------------------------------------
// stage_wait_timer
// Counts cycles a memory request has been outstanding without an ack. Shared
// between FETCH and MEM: the count is held at zero whenever no request is
// outstanding, so it starts from zero on every entry into either state.
//
// Ports:
//   clk      in   rising-edge clock
//   reset    in   asynchronous, active-low
//   active   in   a request is outstanding this cycle
//   ack      in   the matching acknowledge for the outstanding request
//   timeout  out  this is the WAIT_MAX-th cycle without ack (combinational)
// -----------------------------------------------------------------------------
module stage_wait_timer
    import stage_ctrl_pkg::*;
#(
    parameter int WAIT_MAX = 15,
    parameter int WAIT_W   = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic active,
    input  logic ack,
    output logic timeout
);

    logic [WAIT_W-1:0] cnt_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else if (!active || ack) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + WAIT_W'(1);
        end
    end

    // cnt_q holds the number of earlier waiting cycles, so the current cycle
    // is the WAIT_MAX-th one when cnt_q == WAIT_MAX-1. An ack in that same
    // cycle suppresses the timeout.
    assign timeout = active && !ack && (cnt_q == WAIT_W'(WAIT_MAX - 1));

endmodule

// File: rtl/stage_ctrl.sv
// -----------------------------------------------------------------------------
// stage_ctrl
// Multi-cycle control FSM for the RV32I core. Sequences fetch, decode,
// execute, memory and writeback; owns the instruction/data memory handshakes,
// the register-file write strobe, PC update strobes, and halt/fault reporting.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | core stopped, waiting for run_i
// FETCH  | imem_req_o high until imem_ack_i (IR loaded on ack)
// DECODE | one cycle; illegal class halts, otherwise latch the class
// EXEC   | one cycle; loads/stores go to MEM, everything else to WB
// MEM    | dmem_req_o high until dmem_ack_i
// WB     | one cycle; register write, PC update, pick next state
// HALT   | sticky until reset; fault_o holds the cause
//
// Ports:
//   clk, reset (async, active-low)
//   run_i, halt_req_i, itype_i[4:0], branch_taken_i, imem_ack_i, dmem_ack_i
//   stage_o[2:0], imem_req_o, ir_we_o, dmem_req_o, dmem_we_o, rf_we_o,
//   pc_we_o, pc_sel_o, halted_o, fault_o[1:0]
//   cycle_cnt_o[31:0], retire_cnt_o[31:0]  (only with STAGE_CTRL_PERF_EN)
//
// Build option: define STAGE_CTRL_PERF_EN to add the cycle and retired-
// instruction counters.
// -----------------------------------------------------------------------------
module stage_ctrl
    import stage_ctrl_pkg::*;
#(
    parameter int WAIT_MAX = 15,
    parameter int WAIT_W   = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        run_i,
    input  logic        halt_req_i,
    input  logic [4:0]  itype_i,
    input  logic        branch_taken_i,
    input  logic        imem_ack_i,
    input  logic        dmem_ack_i,
    output logic [2:0]  stage_o,
    output logic        imem_req_o,
    output logic        ir_we_o,
    output logic        dmem_req_o,
    output logic        dmem_we_o,
    output logic        rf_we_o,
    output logic        pc_we_o,
    output logic        pc_sel_o,
    output logic        halted_o,
    output logic [1:0]  fault_o
`ifdef STAGE_CTRL_PERF_EN
    ,
    output logic [31:0] cycle_cnt_o,
    output logic [31:0] retire_cnt_o
`endif
);

    stage_e     state_q;
    logic [4:0] itype_q;
    logic       imem_req_q;
    logic       dmem_req_q;
    logic       dmem_we_q;
    logic       rf_we_q;
    logic       pc_we_q;
    logic       halted_q;
    fault_e     fault_q;

    logic       wait_active;
    logic       wait_ack;
    logic       wait_timeout;

    // Only the ack that matches the request of the current state is seen by
    // the timer and the FSM; the other ack is ignored.
    assign wait_active = (state_q == ST_FETCH) || (state_q == ST_MEM);
    assign wait_ack    = (state_q == ST_FETCH) ? imem_ack_i : dmem_ack_i;

    stage_wait_timer #(
        .WAIT_MAX (WAIT_MAX),
        .WAIT_W   (WAIT_W)
    ) u_wait_timer (
        .clk     (clk),
        .reset   (reset),
        .active  (wait_active),
        .ack     (wait_ack),
        .timeout (wait_timeout)
    );

    // Registered outputs are computed for the state being entered, so they
    // are valid for exactly the cycles spent in that state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            itype_q    <= IT_ILLEGAL;
            imem_req_q <= 1'b0;
            dmem_req_q <= 1'b0;
            dmem_we_q  <= 1'b0;
            rf_we_q    <= 1'b0;
            pc_we_q    <= 1'b0;
            halted_q   <= 1'b0;
            fault_q    <= FAULT_NONE;
        end else begin
            imem_req_q <= 1'b0;
            dmem_req_q <= 1'b0;
            dmem_we_q  <= 1'b0;
            rf_we_q    <= 1'b0;
            pc_we_q    <= 1'b0;

            case (state_q)
                ST_IDLE: begin
                    if (run_i) begin
                        state_q    <= ST_FETCH;
                        imem_req_q <= 1'b1;
                    end
                end

                ST_FETCH: begin
                    if (imem_ack_i) begin
                        state_q <= ST_DECODE;
                    end else if (wait_timeout) begin
                        state_q  <= ST_HALT;
                        halted_q <= 1'b1;
                        fault_q  <= FAULT_BUS;
                    end else begin
                        imem_req_q <= 1'b1;
                    end
                end

                ST_DECODE: begin
                    itype_q <= itype_i;
                    if (itype_i == IT_ILLEGAL) begin
                        state_q  <= ST_HALT;
                        halted_q <= 1'b1;
                        fault_q  <= FAULT_ILLEGAL;
                    end else begin
                        state_q <= ST_EXEC;
                    end
                end

                ST_EXEC: begin
                    if (itype_is_mem(itype_q)) begin
                        state_q    <= ST_MEM;
                        dmem_req_q <= 1'b1;
                        dmem_we_q  <= (itype_q == IT_STYPE);
                    end else begin
                        state_q <= ST_WB;
                        rf_we_q <= itype_writes_rf(itype_q);
                        pc_we_q <= 1'b1;
                    end
                end

                ST_MEM: begin
                    if (dmem_ack_i) begin
                        state_q <= ST_WB;
                        rf_we_q <= itype_writes_rf(itype_q);
                        pc_we_q <= 1'b1;
                    end else if (wait_timeout) begin
                        state_q  <= ST_HALT;
                        halted_q <= 1'b1;
                        fault_q  <= FAULT_BUS;
                    end else begin
                        dmem_req_q <= 1'b1;
                        dmem_we_q  <= (itype_q == IT_STYPE);
                    end
                end

                ST_WB: begin
                    // A halt request beats both continuing and stopping.
                    if (halt_req_i) begin
                        state_q  <= ST_HALT;
                        halted_q <= 1'b1;
                    end else if (run_i) begin
                        state_q    <= ST_FETCH;
                        imem_req_q <= 1'b1;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end

                ST_HALT: begin
                    state_q <= ST_HALT;
                end

                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign stage_o    = state_q;
    assign imem_req_o = imem_req_q;
    assign dmem_req_o = dmem_req_q;
    assign dmem_we_o  = dmem_we_q;
    assign rf_we_o    = rf_we_q;
    assign pc_we_o    = pc_we_q;
    assign halted_o   = halted_q;
    assign fault_o    = fault_q;

    // IR data is valid in the ack cycle itself, so the load strobe is the ack
    // qualified by the registered FETCH state.
    assign ir_we_o = (state_q == ST_FETCH) && imem_ack_i;

    // branch_taken_i is only valid during WB; qualified by the registered
    // WB state and the class latched at decode.
    assign pc_sel_o = (state_q == ST_WB) &&
                      (itype_is_jump(itype_q) ||
                       ((itype_q == IT_BTYPE) && branch_taken_i));

`ifdef STAGE_CTRL_PERF_EN
    logic [31:0] cycle_cnt_q;
    logic [31:0] retire_cnt_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cycle_cnt_q  <= '0;
            retire_cnt_q <= '0;
        end else begin
            if ((state_q != ST_IDLE) && (state_q != ST_HALT)) begin
                cycle_cnt_q <= cycle_cnt_q + 32'd1;
            end
            if (state_q == ST_WB) begin
                retire_cnt_q <= retire_cnt_q + 32'd1;
            end
        end
    end

    assign cycle_cnt_o  = cycle_cnt_q;
    assign retire_cnt_o = retire_cnt_q;
`endif

endmodule

// File: tb/tb_stage_ctrl.sv
// -----------------------------------------------------------------------------
// tb_stage_ctrl
// Self-checking bench for stage_ctrl. Each instruction is described at the
// level of "class, fetch wait, memory wait, branch outcome, what happens at
// writeback"; the expected per-cycle outputs are derived from those rules.
// Inputs that the current stage must ignore are randomised every cycle.
// -----------------------------------------------------------------------------
module tb_stage_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       run_i = 1'b0;
    logic       halt_req_i = 1'b0;
    logic [4:0] itype_i = 5'd0;
    logic       branch_taken_i = 1'b0;
    logic       imem_ack_i = 1'b0;
    logic       dmem_ack_i = 1'b0;
    logic [2:0] stage_o;
    logic       imem_req_o;
    logic       ir_we_o;
    logic       dmem_req_o;
    logic       dmem_we_o;
    logic       rf_we_o;
    logic       pc_we_o;
    logic       pc_sel_o;
    logic       halted_o;
    logic [1:0] fault_o;

    int checks = 0;
    int failures = 0;
    bit need_start = 1'b1;

    stage_ctrl #(.WAIT_MAX(15), .WAIT_W(4)) dut (
        .clk            (clk),
        .reset          (reset),
        .run_i          (run_i),
        .halt_req_i     (halt_req_i),
        .itype_i        (itype_i),
        .branch_taken_i (branch_taken_i),
        .imem_ack_i     (imem_ack_i),
        .dmem_ack_i     (dmem_ack_i),
        .stage_o        (stage_o),
        .imem_req_o     (imem_req_o),
        .ir_we_o        (ir_we_o),
        .dmem_req_o     (dmem_req_o),
        .dmem_we_o      (dmem_we_o),
        .rf_we_o        (rf_we_o),
        .pc_we_o        (pc_we_o),
        .pc_sel_o       (pc_sel_o),
        .halted_o       (halted_o),
        .fault_o        (fault_o)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // {stage, imem_req, ir_we, dmem_req, dmem_we, rf_we, pc_we, pc_sel, halted, fault}
    function automatic logic [12:0] pack_out();
        return {stage_o, imem_req_o, ir_we_o, dmem_req_o, dmem_we_o,
                rf_we_o, pc_we_o, pc_sel_o, halted_o, fault_o};
    endfunction

    // Called at a falling edge after the inputs for this cycle are set.
    task automatic expect_cyc(input string tag, input logic [2:0] st,
                              input bit imem, input bit ir, input bit dreq, input bit dwe,
                              input bit rf, input bit pc, input bit sel, input bit hl,
                              input logic [1:0] flt);
        #1;
        check_eq(tag, {19'd0, pack_out()},
                 {19'd0, st, imem, ir, dreq, dwe, rf, pc, sel, hl, flt});
        @(negedge clk);
    endtask

    task automatic noise();
        run_i          = 1'($urandom);
        halt_req_i     = 1'($urandom);
        branch_taken_i = 1'($urandom);
        imem_ack_i     = 1'($urandom);
        dmem_ack_i     = 1'($urandom);
        itype_i        = 5'($urandom);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        noise();
        #1;
        check_eq("reset_outputs", {19'd0, pack_out()}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        need_start = 1'b1;
    endtask

    task automatic start_from_idle();
        noise(); run_i = 1'b0;
        expect_cyc("idle_wait", 3'd0, 0,0,0,0,0,0,0,0, 2'd0);
        noise(); run_i = 1'b1;
        expect_cyc("idle_go", 3'd0, 0,0,0,0,0,0,0,0, 2'd0);
        need_start = 1'b0;
    endtask

    task automatic halt_check(input logic [1:0] flt);
        repeat (3) begin
            noise(); run_i = 1'b1;
            expect_cyc("halt_sticky", 3'd6, 0,0,0,0,0,0,0,1, flt);
        end
        do_reset();
    endtask

    // di/dd: wait cycles before ack; 15 or more means the ack never comes.
    task automatic run_instr(input logic [4:0] t, input int di, input int dd,
                             input bit bt, input bit rw, input bit hw);
        int nf;
        int nm;
        bit mem;
        bit exp_rf;
        bit exp_sel;
        if (need_start) start_from_idle();
        mem     = (t == 5'd3) || (t == 5'd5);
        exp_rf  = (t == 5'd1) || (t == 5'd2) || (t == 5'd5) || (t == 5'd6) ||
                  (t == 5'd7) || (t == 5'd8);
        exp_sel = (t == 5'd7) || (t == 5'd8) || ((t == 5'd4) && bt);

        nf = (di >= 15) ? 15 : di + 1;
        for (int k = 0; k < nf; k++) begin
            noise(); imem_ack_i = (k == di);
            expect_cyc("fetch", 3'd1, 1, (k == di), 0,0,0,0,0,0, 2'd0);
        end
        if (di >= 15) begin halt_check(2'd2); return; end

        noise(); itype_i = t;
        expect_cyc("decode", 3'd2, 0,0,0,0,0,0,0,0, 2'd0);
        if (t == 5'd0) begin halt_check(2'd1); return; end

        noise(); itype_i = t;
        expect_cyc("exec", 3'd3, 0,0,0,0,0,0,0,0, 2'd0);

        if (mem) begin
            nm = (dd >= 15) ? 15 : dd + 1;
            for (int k = 0; k < nm; k++) begin
                noise(); itype_i = t; dmem_ack_i = (k == dd);
                expect_cyc("mem", 3'd4, 0,0,1, (t == 5'd3), 0,0,0,0, 2'd0);
            end
            if (dd >= 15) begin halt_check(2'd2); return; end
        end

        noise(); itype_i = t; branch_taken_i = bt; halt_req_i = hw; run_i = rw;
        expect_cyc("wb", 3'd5, 0,0,0,0, exp_rf, 1, exp_sel, 0, 2'd0);
        if (hw) begin halt_check(2'd0); return; end
        need_start = !rw;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [4:0] t;
        int di;
        int dd;
        int r;

        @(negedge clk);
        do_reset();

        // Directed cases
        run_instr(5'd1, 0, 0, 1'b0, 1'b0, 1'b0);   // R-type, zero wait, then idle
        run_instr(5'd5, 0, 3, 1'b0, 1'b1, 1'b0);   // load, 3 dmem wait cycles
        run_instr(5'd3, 0, 0, 1'b0, 1'b1, 1'b0);   // store
        run_instr(5'd4, 0, 0, 1'b1, 1'b1, 1'b0);   // taken branch
        run_instr(5'd4, 1, 0, 1'b0, 1'b1, 1'b0);   // not-taken branch
        run_instr(5'd7, 14, 0, 1'b0, 1'b1, 1'b0);  // fetch ack on last allowed cycle
        run_instr(5'd5, 0, 14, 1'b0, 1'b0, 1'b0);  // mem ack on last allowed cycle
        run_instr(5'd2, 0, 0, 1'b0, 1'b0, 1'b1);   // halt_req with run_i low
        run_instr(5'd0, 0, 0, 1'b0, 1'b1, 1'b0);   // illegal instruction
        run_instr(5'd1, 15, 0, 1'b0, 1'b1, 1'b0);  // fetch timeout
        run_instr(5'd3, 0, 15, 1'b0, 1'b1, 1'b0);  // mem timeout

        // Asynchronous reset in the middle of a data request
        start_from_idle();
        noise(); imem_ack_i = 1'b1;
        expect_cyc("rst_fetch", 3'd1, 1,1,0,0,0,0,0,0, 2'd0);
        noise(); itype_i = 5'd5;
        expect_cyc("rst_decode", 3'd2, 0,0,0,0,0,0,0,0, 2'd0);
        noise(); itype_i = 5'd5;
        expect_cyc("rst_exec", 3'd3, 0,0,0,0,0,0,0,0, 2'd0);
        noise(); itype_i = 5'd5; dmem_ack_i = 1'b0;
        expect_cyc("rst_mem", 3'd4, 0,0,1,0,0,0,0,0, 2'd0);
        noise(); itype_i = 5'd5; dmem_ack_i = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        check_eq("rst_async_dreq", {31'd0, dmem_req_o}, 32'd0);
        check_eq("rst_async_stage", {29'd0, stage_o}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        need_start = 1'b1;
        run_instr(5'd6, 0, 0, 1'b0, 1'b1, 1'b0);   // fetch resumes after reset

        // Randomised instruction stream
        for (int n = 0; n < 60; n++) begin
            t  = ($urandom_range(0, 19) == 0) ? 5'd0 : 5'($urandom_range(1, 8));
            r  = $urandom_range(0, 19);
            di = (r == 0) ? 15 : (r == 1) ? 14 : $urandom_range(0, 3);
            r  = $urandom_range(0, 19);
            dd = (r == 0) ? 15 : (r == 1) ? 14 : $urandom_range(0, 3);
            run_instr(t, di, dd, 1'($urandom), ($urandom_range(0, 3) != 0),
                      ($urandom_range(0, 9) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
